instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 159 +++++++++++++++
 tb/tb_instr_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches program words, decodes the opcode and steps the
// datapath through FETCH/EXEC/WAIT/WB, with sticky illegal-opcode and ALU-timeout flags.
module instr_sequencer #(
  parameter int unsigned PROG_LEN    = 25,
  parameter int unsigned ALU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] addr,
  input  logic [15:0] fncode,
  input  logic [15:0] data,
  input  logic [15:0] rx_val,
  output logic [3:0]  rx_sel,
  output logic [3:0]  ry_sel,
  output logic [3:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        reg_we,
  output logic [1:0]  wd_sel,
  output logic [15:0] imm,
  output logic        busy,
  output logic        done,
  output logic        err_illegal,
  output logic        err_timeout
);

  localparam int unsigned CntW      = $clog2(ALU_TIMEOUT + 1);
  localparam logic [16:0] ProgLen   = 17'(PROG_LEN);
  localparam logic [CntW-1:0] CntLast = CntW'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StWait, StWb} state_e;

  state_e          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [11:0]     ir_q, ir_d;
  logic [15:0]     imm_q, imm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ill_q, ill_d;
  logic            to_q, to_d;

  logic [3:0] op;
  logic       is_multi;
  logic       is_illegal;
  logic       past_end;
  logic       unused_fncode;

  // Low nibble of the instruction word carries no information.
  assign unused_fncode = ^fncode[3:0];

  assign op         = ir_q[11:8];
  assign is_multi   = (op == 4'd7) || (op == 4'd8) || (op == 4'd10);
  assign is_illegal = (op >= 4'd11);
  assign past_end   = ({1'b0, pc_q} >= ProgLen);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;
    ill_d     = ill_q;
    to_d      = to_q;
    alu_start = 1'b0;
    reg_we    = 1'b0;
    done      = 1'b0;
    wd_sel    = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = '0;
          ill_d   = 1'b0;
          to_d    = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (past_end) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          ir_d    = fncode[15:4];
          imm_d   = data;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_illegal) begin
          ill_d   = 1'b1;
          state_d = StIdle;
        end else if (op == 4'd3) begin
          pc_d    = rx_val;
          state_d = StFetch;
        end else if (is_multi) begin
          alu_start = 1'b1;
          cnt_d     = '0;
          state_d   = StWait;
        end else begin
          state_d = StWb;
        end
      end
      StWait: begin
        // alu_done on the last allowed cycle still wins over the timeout.
        if (alu_done) begin
          state_d = StWb;
        end else if (cnt_q == CntLast) begin
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        pc_d    = pc_q + 16'd1;
        state_d = StFetch;
        case (op)
          4'd0:    wd_sel = 2'd1;
          4'd1:    wd_sel = 2'd2;
          4'd2:    wd_sel = 2'd3;
          default: wd_sel = 2'd0;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  assign addr        = pc_q;
  assign busy        = (state_q != StIdle);
  assign alu_op      = ir_q[11:8];
  assign rx_sel      = ir_q[7:4];
  assign ry_sel      = ir_q[3:0];
  assign imm         = imm_q;
  assign err_illegal = ill_q;
  assign err_timeout = to_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Random-program bench: an instruction-level model expands each run into a per-cycle
// table of stimulus and expected outputs, which is then replayed against the sequencer.
module tb_instr_sequencer;

  localparam int unsigned ProgLen    = 25;
  localparam int unsigned AluTimeout = 64;

  logic        clk = 1'b0;
  logic        reset, start, alu_done;
  logic [15:0] addr, fncode, data, rx_val, imm;
  logic [3:0]  rx_sel, ry_sel, alu_op;
  logic        alu_start, reg_we, busy, done, err_illegal, err_timeout;
  logic [1:0]  wd_sel;

  logic [15:0] prog [32];
  logic [15:0] dmem [32];
  logic [15:0] tgt  [32];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_idx = 0;

  always #5 clk = ~clk;

  assign fncode = prog[addr[4:0]];
  assign data   = dmem[addr[4:0]];

  instr_sequencer #(.PROG_LEN(ProgLen), .ALU_TIMEOUT(AluTimeout)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .fncode(fncode), .data(data),
    .rx_val(rx_val), .rx_sel(rx_sel), .ry_sel(ry_sel), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .reg_we(reg_we), .wd_sel(wd_sel),
    .imm(imm), .busy(busy), .done(done), .err_illegal(err_illegal),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic        rst, start, alu_done;
    logic [15:0] rx_val;
    logic [15:0] addr;
    logic        busy, reg_we, alu_start, done, e_ill, e_to;
    logic [1:0]  wd_sel;
    logic        chk_ir;
    logic [3:0]  op, rx, ry;
    logic [15:0] imm;
  } cyc_t;

  cyc_t q[$];

  // Architectural view of the model: PC, error flags and the instruction in flight.
  logic [15:0] m_pc;
  logic        m_ill, m_to;
  logic [3:0]  m_op, m_rx, m_ry;
  logic [15:0] m_imm;

  function automatic cyc_t base();
    cyc_t c;
    c.rst       = 1'b0;
    c.start     = ($urandom_range(0, 3) == 0);
    c.alu_done  = 1'($urandom_range(0, 1));
    c.rx_val    = 16'($urandom);
    c.addr      = m_pc;
    c.busy      = 1'b1;
    c.reg_we    = 1'b0;
    c.alu_start = 1'b0;
    c.done      = 1'b0;
    c.e_ill     = m_ill;
    c.e_to      = m_to;
    c.wd_sel    = 2'd0;
    c.chk_ir    = 1'b0;
    c.op        = m_op;
    c.rx        = m_rx;
    c.ry        = m_ry;
    c.imm       = m_imm;
    return c;
  endfunction

  task automatic push_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c       = base();
      c.busy  = 1'b0;
      c.start = 1'b0;
      q.push_back(c);
    end
  endtask

  task automatic gen_program();
    int unsigned r;
    for (int i = 0; i < 32; i++) begin
      r = $urandom_range(0, 39);
      prog[i][15:12] = (r < 37) ? 4'(r % 11) : 4'(11 + $urandom_range(0, 4));
      prog[i][11:0]  = 12'($urandom);
      dmem[i]        = 16'($urandom);
      tgt[i]         = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(ProgLen, 16'hffff))
                                                   : 16'(i + 1 + $urandom_range(0, 3));
    end
  endtask

  // Walks the program one instruction at a time, emitting the cycles each one costs.
  task automatic gen_run();
    cyc_t c;
    bit   fin;
    bit   tmo;
    int   n;
    c       = base();
    c.busy  = 1'b0;
    c.start = 1'b1;
    q.push_back(c);
    m_pc  = '0;
    m_ill = 1'b0;
    m_to  = 1'b0;
    fin   = 1'b0;
    while (!fin) begin
      c = base();
      if (m_pc >= ProgLen) begin
        c.done = 1'b1;
        q.push_back(c);
        fin = 1'b1;
      end else begin
        q.push_back(c);
        m_op  = prog[m_pc[4:0]][15:12];
        m_rx  = prog[m_pc[4:0]][11:8];
        m_ry  = prog[m_pc[4:0]][7:4];
        m_imm = dmem[m_pc[4:0]];
        c = base();
        c.chk_ir = 1'b1;
        if (m_op >= 4'd11) begin
          q.push_back(c);
          m_ill = 1'b1;
          fin   = 1'b1;
        end else if (m_op == 4'd3) begin
          c.rx_val = tgt[m_pc[4:0]];
          q.push_back(c);
          m_pc = tgt[m_pc[4:0]];
        end else begin
          if (m_op == 4'd7 || m_op == 4'd8 || m_op == 4'd10) begin
            c.alu_start = 1'b1;
            q.push_back(c);
            tmo = ($urandom_range(0, 11) == 0);
            n   = tmo ? AluTimeout : $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
              c          = base();
              c.chk_ir   = 1'b1;
              c.alu_done = !tmo && (k == n - 1);
              q.push_back(c);
            end
            if (tmo) begin
              m_to = 1'b1;
              fin  = 1'b1;
            end
          end else begin
            q.push_back(c);
          end
          if (!fin) begin
            c        = base();
            c.chk_ir = 1'b1;
            c.reg_we = 1'b1;
            c.wd_sel = (m_op == 4'd0) ? 2'd1 : (m_op == 4'd1) ? 2'd2 :
                       (m_op == 4'd2) ? 2'd3 : 2'd0;
            q.push_back(c);
            m_pc = m_pc + 16'd1;
          end
        end
      end
    end
  endtask

  // Cut the run short and hit reset; everything must read zero and stay quiet afterwards.
  task automatic plant_reset();
    cyc_t c;
    int   keep;
    keep = $urandom_range(1, q.size() - 1);
    while (q.size() > keep) void'(q.pop_back());
    m_pc  = '0;
    m_ill = 1'b0;
    m_to  = 1'b0;
    m_op  = '0;
    m_rx  = '0;
    m_ry  = '0;
    m_imm = '0;
    c        = base();
    c.rst    = 1'b1;
    c.start  = 1'b0;
    c.busy   = 1'b0;
    c.chk_ir = 1'b1;
    q.push_back(c);
    for (int i = 0; i < 3; i++) begin
      c        = base();
      c.start  = 1'b0;
      c.busy   = 1'b0;
      c.chk_ir = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc_idx, obs, exp);
    end
  endtask

  task automatic replay();
    cyc_t c;
    foreach (q[i]) begin
      c = q[i];
      @(posedge clk);
      #1;
      reset    = c.rst;
      start    = c.start;
      alu_done = c.alu_done;
      rx_val   = c.rx_val;
      @(negedge clk);
      chk("busy", 16'(busy), 16'(c.busy));
      chk("addr", addr, c.addr);
      chk("reg_we", 16'(reg_we), 16'(c.reg_we));
      chk("alu_start", 16'(alu_start), 16'(c.alu_start));
      chk("done", 16'(done), 16'(c.done));
      chk("err_illegal", 16'(err_illegal), 16'(c.e_ill));
      chk("err_timeout", 16'(err_timeout), 16'(c.e_to));
      if (c.reg_we || c.rst) chk("wd_sel", 16'(wd_sel), 16'(c.wd_sel));
      if (c.chk_ir) begin
        chk("alu_op", 16'(alu_op), 16'(c.op));
        chk("rx_sel", 16'(rx_sel), 16'(c.rx));
        chk("ry_sel", 16'(ry_sel), 16'(c.ry));
        chk("imm", imm, c.imm);
      end
      cyc_idx++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    alu_done = 1'b0;
    rx_val   = '0;
    for (int i = 0; i < 32; i++) begin
      prog[i] = '0;
      dmem[i] = '0;
      tgt[i]  = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_addr", addr, 16'd0);
    chk("rst_outs", {11'd0, reg_we, alu_start, done, err_illegal, err_timeout}, 16'd0);
    chk("rst_ir", {alu_op, rx_sel, ry_sel, 4'd0}, 16'd0);
    chk("rst_imm", imm, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    m_pc  = '0;
    m_ill = 1'b0;
    m_to  = 1'b0;
    m_op  = '0;
    m_rx  = '0;
    m_ry  = '0;
    m_imm = '0;

    for (int run = 0; run < 40; run++) begin
      q.delete();
      gen_program();
      gen_run();
      if ($urandom_range(0, 3) == 0 && q.size() > 1) plant_reset();
      push_idle($urandom_range(1, 3));
      replay();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
